// File: rtl/robot_status_pkg.sv
// ----------------------------------------------------------------------------
// robot_status_pkg
// Shared definitions for the robot status path: the 4-bit one-hot status codes
// understood by the seven-segment display decoder, the overcurrent FSM state
// type, and the sensor priority helper used by the code mux.
// ----------------------------------------------------------------------------
package robot_status_pkg;

  // Status codes shared with the display decoder.
  localparam logic [3:0] CODE_NONE   = 4'b0000;
  localparam logic [3:0] CODE_LEFT   = 4'b1000;
  localparam logic [3:0] CODE_CENTER = 4'b0100;
  localparam logic [3:0] CODE_RIGHT  = 4'b0010;
  localparam logic [3:0] CODE_OC     = 4'b0001;

  // Indices of the debounced inputs inside the top-level input vector.
  localparam int IDX_L  = 0;
  localparam int IDX_C  = 1;
  localparam int IDX_R  = 2;
  localparam int IDX_OC = 3;
  localparam int NUM_INPUTS = 4;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_OC_HOLD  = 2'd1,
    S_OC_LATCH = 2'd2
  } oc_state_t;

  // Line-sensor code with priority centre > left > right.
  function automatic logic [3:0] sensor_code(input logic deb_l,
                                             input logic deb_c,
                                             input logic deb_r);
    logic [3:0] code;
    if (deb_c) begin
      code = CODE_CENTER;
    end else if (deb_l) begin
      code = CODE_LEFT;
    end else if (deb_r) begin
      code = CODE_RIGHT;
    end else begin
      code = CODE_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
// Two-flop synchroniser followed by a counting debouncer. The debounced level
// only follows the synchronised input after the two have disagreed for
// DEBOUNCE_CYCLES consecutive cycles; any shorter excursion is discarded.
//
// Ports
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   raw_i  in  raw asynchronous input
//   deb_o  out debounced, clk-synchronous level
// ----------------------------------------------------------------------------
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the disagreement has lasted DEBOUNCE_CYCLES cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      // Disagreement has persisted long enough: accept the new level.
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/robot_status_encoder.sv
// ----------------------------------------------------------------------------
// robot_status_encoder
// Feeds the seven-segment status display. Debounces the three line sensors
// and the overcurrent comparator, runs the overcurrent hold/latch FSM and
// registers the resulting 4-bit status code.
//
// Ports
//   clk           in  system clock (sole domain)
//   rst           in  asynchronous active-high reset
//   sens_l/c/r    in  raw line sensors, active-high, asynchronous
//   oc_in         in  raw overcurrent comparator, active-high, asynchronous
//   oc_clear      in  level request to clear a latched overcurrent
//   number        out registered status code
//   code_changed  out one-cycle pulse in the first cycle number shows a new value
//   oc_flag       out high while the FSM is in S_OC_HOLD or S_OC_LATCH
// ----------------------------------------------------------------------------
module robot_status_encoder
  import robot_status_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int OC_HOLD_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sens_l,
  input  logic       sens_c,
  input  logic       sens_r,
  input  logic       oc_in,
  input  logic       oc_clear,
  output logic [3:0] number,
  output logic       code_changed,
  output logic       oc_flag
);

  localparam int HW = $clog2(OC_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(OC_HOLD_CYCLES - 1);

  logic [NUM_INPUTS-1:0] raw_vec;
  logic [NUM_INPUTS-1:0] deb_vec;

  assign raw_vec[IDX_L]  = sens_l;
  assign raw_vec[IDX_C]  = sens_c;
  assign raw_vec[IDX_R]  = sens_r;
  assign raw_vec[IDX_OC] = oc_in;

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
      input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .raw_i(raw_vec[gi]),
        .deb_o(deb_vec[gi])
      );
    end
  endgenerate

  logic deb_oc;
  assign deb_oc = deb_vec[IDX_OC];

  oc_state_t     state_q;
  oc_state_t     state_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic [3:0]    number_q;
  logic [3:0]    number_d;
  logic          code_changed_q;
  logic          oc_flag_q;

  // Next-state and hold counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_RUN: begin
        if (deb_oc) begin
          state_d = S_OC_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      S_OC_HOLD: begin
        // oc_clear deliberately has no effect while holding.
        if (hold_q == '0) begin
          state_d = deb_oc ? S_OC_LATCH : S_RUN;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_OC_LATCH: begin
        if (!deb_oc && oc_clear) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // The code follows the next state so that number, oc_flag and the FSM
  // state all change on the same edge; the S_RUN cycle in which deb_oc rises
  // already selects the overcurrent code.
  always_comb begin
    if (state_d != S_RUN) begin
      number_d = CODE_OC;
    end else begin
      number_d = sensor_code(deb_vec[IDX_L], deb_vec[IDX_C], deb_vec[IDX_R]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      hold_q         <= '0;
      number_q       <= CODE_NONE;
      code_changed_q <= 1'b0;
      oc_flag_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      number_q       <= number_d;
      code_changed_q <= (number_d != number_q);
      oc_flag_q      <= (state_d != S_RUN);
    end
  end

  assign number       = number_q;
  assign code_changed = code_changed_q;
  assign oc_flag      = oc_flag_q;

endmodule

// File: tb/tb_robot_status_encoder.sv
// ----------------------------------------------------------------------------
// tb_robot_status_encoder
// Directed stimulus with hand-computed expectations for the status encoder,
// run with DEBOUNCE_CYCLES=4 and OC_HOLD_CYCLES=8 (raw edge to number = 7
// clock edges, overcurrent code shown for 8 cycles).
// ----------------------------------------------------------------------------
module tb_robot_status_encoder;
  import robot_status_pkg::*;

  logic       clk;
  logic       rst;
  logic       sens_l;
  logic       sens_c;
  logic       sens_r;
  logic       oc_in;
  logic       oc_clear;
  logic [3:0] number;
  logic       code_changed;
  logic       oc_flag;

  int n_cmp = 0;
  int n_err = 0;

  robot_status_encoder #(
    .DEBOUNCE_CYCLES(4),
    .OC_HOLD_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sens_l      (sens_l),
    .sens_c      (sens_c),
    .sens_r      (sens_r),
    .oc_in       (oc_in),
    .oc_clear    (oc_clear),
    .number      (number),
    .code_changed(code_changed),
    .oc_flag     (oc_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("check %-22s observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; sens_l = 1'b0; sens_c = 1'b0; sens_r = 1'b0;
    oc_in = 1'b0; oc_clear = 1'b0;

    // Reset state
    step(2);
    chk("rst_number", number, CODE_NONE);
    chk("rst_code_changed", {3'b0, code_changed}, 4'd0);
    chk("rst_oc_flag", {3'b0, oc_flag}, 4'd0);
    rst = 1'b0;
    step(3);
    chk("post_rst_number", number, CODE_NONE);

    // 3-cycle glitch on sens_r is rejected
    sens_r = 1'b1; step(3); sens_r = 1'b0;
    step(10);
    chk("glitch3_r", number, CODE_NONE);

    // Exactly 4-cycle pulse on sens_r is accepted, then released
    sens_r = 1'b1; step(4); sens_r = 1'b0;
    step(3);
    chk("pulse4_r", number, CODE_RIGHT);
    step(4);
    chk("pulse4_r_release", number, CODE_NONE);
    step(5);

    // sens_l rising: number appears on the 7th edge
    sens_l = 1'b1;
    step(6);
    chk("l_edge6", number, CODE_NONE);
    step(1);
    chk("l_edge7", number, CODE_LEFT);
    chk("l_changed_pulse", {3'b0, code_changed}, 4'd1);
    step(1);
    chk("l_changed_end", {3'b0, code_changed}, 4'd0);

    // Centre beats left; drop centre, then left
    sens_c = 1'b1;
    step(6);
    chk("c_edge6", number, CODE_LEFT);
    step(1);
    chk("c_over_l", number, CODE_CENTER);
    sens_c = 1'b0;
    step(7);
    chk("drop_c", number, CODE_LEFT);
    sens_l = 1'b0;
    step(7);
    chk("drop_all", number, CODE_NONE);

    // Asynchronous reset mid-stream, no clock edge needed
    sens_l = 1'b1;
    step(7);
    chk("pre_arst_number", number, CODE_LEFT);
    #2 rst = 1'b1;
    #1;
    chk("arst_number", number, CODE_NONE);
    chk("arst_code_changed", {3'b0, code_changed}, 4'd0);
    chk("arst_oc_flag", {3'b0, oc_flag}, 4'd0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("arst_release_hold", number, CODE_NONE);
    sens_l = 1'b0;
    step(20);
    chk("arst_settled", number, CODE_NONE);

    // Overcurrent pulse of 6 cycles with centre active
    sens_c = 1'b1;
    step(7);
    chk("oc_pre_center", number, CODE_CENTER);
    oc_in = 1'b1;
    step(6);
    chk("oc_edge6", number, CODE_CENTER);
    chk("oc_edge6_flag", {3'b0, oc_flag}, 4'd0);
    oc_in = 1'b0;
    step(1);
    chk("oc_edge7", number, CODE_OC);
    chk("oc_edge7_flag", {3'b0, oc_flag}, 4'd1);
    chk("oc_edge7_changed", {3'b0, code_changed}, 4'd1);
    step(2);
    oc_clear = 1'b1;
    step(1);
    oc_clear = 1'b0;
    chk("hold_clear_ignored", number, CODE_OC);
    chk("hold_clear_flag", {3'b0, oc_flag}, 4'd1);
    step(4);
    chk("hold_last_cycle", number, CODE_OC);
    step(1);
    chk("hold_expired", number, CODE_CENTER);
    chk("hold_expired_flag", {3'b0, oc_flag}, 4'd0);
    chk("hold_expired_changed", {3'b0, code_changed}, 4'd1);

    // Overcurrent held: latch, clear ignored while active, then released
    sens_c = 1'b0;
    step(10);
    chk("latch_pre_none", number, CODE_NONE);
    oc_in = 1'b1;
    step(7);
    chk("latch_oc_start", number, CODE_OC);
    step(10);
    chk("latch_persist", number, CODE_OC);
    chk("latch_flag", {3'b0, oc_flag}, 4'd1);
    oc_clear = 1'b1;
    step(2);
    chk("latch_clear_ignored", number, CODE_OC);
    oc_clear = 1'b0;
    oc_in = 1'b0;
    step(8);
    chk("latch_after_drop", number, CODE_OC);
    oc_clear = 1'b1;
    step(1);
    chk("latch_cleared", number, CODE_NONE);
    chk("latch_cleared_flag", {3'b0, oc_flag}, 4'd0);
    chk("latch_cleared_changed", {3'b0, code_changed}, 4'd1);
    oc_clear = 1'b0;
    step(1);
    chk("latch_changed_end", {3'b0, code_changed}, 4'd0);

    // Reset while latched
    oc_in = 1'b1;
    step(20);
    chk("relatch_number", number, CODE_OC);
    #2 rst = 1'b1;
    #1;
    chk("latch_arst_number", number, CODE_NONE);
    chk("latch_arst_flag", {3'b0, oc_flag}, 4'd0);
    oc_in = 1'b0;
    step(2);
    rst = 1'b0;
    step(10);
    chk("latch_rel_number", number, CODE_NONE);
    chk("latch_rel_flag", {3'b0, oc_flag}, 4'd0);
    chk("latch_rel_state", 4'(dut.state_q), 4'(S_RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
